// File: rtl/settings_arb_pkg.sv
// Shared types for the settings bus arbiter: FSM state encoding.
package settings_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/settings_bus_arbiter_rr_arbiter.sv
// Rotating priority encoder: picks the first set request after the last granted index.
// With SETTINGS_ARB_HOST_PRIORITY_EN defined, requester 0 always wins when it requests.
module rr_arbiter #(
    parameter int C_NUM_REQ = 4,
    parameter int C_IDXW    = $clog2(C_NUM_REQ)
) (
    input  logic [C_NUM_REQ-1:0] req_i,
    input  logic [C_IDXW-1:0]    last_i,
    output logic [C_IDXW-1:0]    grant_idx_o,
    output logic                 grant_vld_o
);

    logic [C_IDXW-1:0] idx_s;
    logic              hit_s;
    logic [C_IDXW-1:0] grant_idx_s;
    logic              grant_vld_s;

    // Search from last+1 around the ring; the first hit sticks.
    always_comb begin
        grant_idx_s = {C_IDXW{1'b0}};
        grant_vld_s = 1'b0;
        idx_s       = {C_IDXW{1'b0}};
        hit_s       = 1'b0;
        for (int k = 1; k <= C_NUM_REQ; k++) begin
            idx_s       = C_IDXW'((int'(last_i) + k) % C_NUM_REQ);
            hit_s       = !grant_vld_s && req_i[idx_s];
            grant_idx_s = hit_s ? idx_s : grant_idx_s;
            grant_vld_s = grant_vld_s | hit_s;
        end
`ifdef SETTINGS_ARB_HOST_PRIORITY_EN
        grant_idx_s = req_i[0] ? {C_IDXW{1'b0}} : grant_idx_s;
        grant_vld_s = grant_vld_s | req_i[0];
`endif
    end

    assign grant_idx_o = grant_idx_s;
    assign grant_vld_o = grant_vld_s;

endmodule

// File: rtl/settings_bus_arbiter.sv
// Arbitrates several requesters onto one settings write bus and one readback bus.
// Optional build macro: SETTINGS_ARB_HOST_PRIORITY_EN (requester 0 has absolute priority).
module settings_bus_arbiter
    import settings_arb_pkg::*;
#(
    parameter int C_DATAWIDTH = 32,
    parameter int C_ADDRWIDTH = 32,
    parameter int C_NUM_REQ   = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [C_NUM_REQ-1:0]             req,
    input  logic [C_NUM_REQ-1:0]             req_we,
    input  logic [C_NUM_REQ*C_ADDRWIDTH-1:0] req_addr,
    input  logic [C_NUM_REQ*C_DATAWIDTH-1:0] req_wdata,
    output logic [C_NUM_REQ-1:0]             ack,
    output logic [C_DATAWIDTH-1:0]           rdata,
    output logic [C_DATAWIDTH-1:0]           set_data,
    output logic                             set_stb,
    output logic [C_ADDRWIDTH-1:0]           set_addr,
    output logic [C_ADDRWIDTH-1:0]           get_addr,
    input  logic [C_DATAWIDTH-1:0]           get_data,
    output logic                             busy
);

    localparam int C_IDXW = $clog2(C_NUM_REQ);

    arb_state_t              state_q;
    logic [C_IDXW-1:0]       last_q;
    logic [C_NUM_REQ-1:0]    ack_q;
    logic [C_NUM_REQ-1:0]    ack_d;
    logic [C_DATAWIDTH-1:0]  rdata_q;
    logic [C_DATAWIDTH-1:0]  set_data_q;
    logic                    set_stb_q;
    logic [C_ADDRWIDTH-1:0]  set_addr_q;
    logic [C_ADDRWIDTH-1:0]  get_addr_q;
    logic                    busy_q;

    logic [C_IDXW-1:0]       grant_idx_s;
    logic                    grant_vld_s;
    logic [C_ADDRWIDTH-1:0]  addr_arr_s  [C_NUM_REQ];
    logic [C_DATAWIDTH-1:0]  wdata_arr_s [C_NUM_REQ];

    for (genvar g = 0; g < C_NUM_REQ; g++) begin : g_unpack
        assign addr_arr_s[g]  = req_addr[g*C_ADDRWIDTH +: C_ADDRWIDTH];
        assign wdata_arr_s[g] = req_wdata[g*C_DATAWIDTH +: C_DATAWIDTH];
    end

    rr_arbiter #(
        .C_NUM_REQ (C_NUM_REQ),
        .C_IDXW    (C_IDXW)
    ) u_rr_arbiter (
        .req_i       (req),
        .last_i      (last_q),
        .grant_idx_o (grant_idx_s),
        .grant_vld_o (grant_vld_s)
    );

    assign ack_d = {{(C_NUM_REQ-1){1'b0}}, 1'b1} << last_q;

    // Transaction FSM; last_q doubles as the index of the transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            last_q     <= C_IDXW'(C_NUM_REQ - 1);
            ack_q      <= {C_NUM_REQ{1'b0}};
            rdata_q    <= {C_DATAWIDTH{1'b0}};
            set_data_q <= {C_DATAWIDTH{1'b0}};
            set_stb_q  <= 1'b0;
            set_addr_q <= {C_ADDRWIDTH{1'b0}};
            get_addr_q <= {C_ADDRWIDTH{1'b0}};
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ack_q <= {C_NUM_REQ{1'b0}};
                    if (grant_vld_s) begin
                        last_q <= grant_idx_s;
                        busy_q <= 1'b1;
                        if (req_we[grant_idx_s]) begin
                            state_q    <= ST_WRITE;
                            set_stb_q  <= 1'b1;
                            set_addr_q <= addr_arr_s[grant_idx_s];
                            set_data_q <= wdata_arr_s[grant_idx_s];
                        end else begin
                            state_q    <= ST_READ;
                            get_addr_q <= addr_arr_s[grant_idx_s];
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    set_stb_q <= 1'b0;
                    ack_q     <= ack_d;
                    state_q   <= ST_DONE;
                end
                ST_READ: begin
                    rdata_q <= get_data;
                    ack_q   <= ack_d;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    ack_q   <= {C_NUM_REQ{1'b0}};
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ack_q     <= {C_NUM_REQ{1'b0}};
                    set_stb_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack      = ack_q;
    assign rdata    = rdata_q;
    assign set_data = set_data_q;
    assign set_stb  = set_stb_q;
    assign set_addr = set_addr_q;
    assign get_addr = get_addr_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_settings_bus_arbiter.sv
// Directed self-checking bench for settings_bus_arbiter (4 requesters, 32-bit buses).
module tb_settings_bus_arbiter;

    localparam int NR = 4;

    logic           clk;
    logic           rst;
    logic [NR-1:0]  req;
    logic [NR-1:0]  req_we;
    logic [NR*32-1:0] req_addr;
    logic [NR*32-1:0] req_wdata;
    logic [NR-1:0]  ack;
    logic [31:0]    rdata;
    logic [31:0]    set_data;
    logic           set_stb;
    logic [31:0]    set_addr;
    logic [31:0]    get_addr;
    logic [31:0]    get_data;
    logic           busy;

    int checks   = 0;
    int failures = 0;

    settings_bus_arbiter #(
        .C_DATAWIDTH (32),
        .C_ADDRWIDTH (32),
        .C_NUM_REQ   (NR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ack       (ack),
        .rdata     (rdata),
        .set_data  (set_data),
        .set_stb   (set_stb),
        .set_addr  (set_addr),
        .get_addr  (get_addr),
        .get_data  (get_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Readback model of the settings register file
    assign get_data = (get_addr == 32'h0) ? 32'hACE0BA53 : (get_addr ^ 32'h5A5A0000);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic [31:0] a, input logic [31:0] d);
        req_we[i]           = we;
        req_addr[i*32 +: 32]  = a;
        req_wdata[i*32 +: 32] = d;
    endtask

    function automatic logic [31:0] onehot(input int i);
        logic [3:0] one_v;
        one_v = 4'b0001;
        return 32'(one_v << i);
    endfunction

    int order4 [5];
    int order2 [3];

    initial begin
`ifdef SETTINGS_ARB_HOST_PRIORITY_EN
        order4 = '{0, 0, 0, 0, 0};
        order2 = '{0, 0, 0};
`else
        order4 = '{0, 1, 2, 3, 0};
        order2 = '{3, 0, 3};
`endif
        rst = 1'b1;
        req = 4'b0000;
        req_we = 4'b0000;
        req_addr = '0;
        req_wdata = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_stb", 32'(set_stb), 32'd0);
        check("rst_set_addr", set_addr, 32'd0);
        check("rst_set_data", set_data, 32'd0);
        check("rst_get_addr", get_addr, 32'd0);
        check("rst_rdata", rdata, 32'd0);

        // Single write from requester 1
        rst = 1'b0;
        set_req(1, 1'b1, 32'h8, 32'h3);
        req = 4'b0010;
        @(negedge clk);
        check("wr_stb", 32'(set_stb), 32'd1);
        check("wr_addr", set_addr, 32'h8);
        check("wr_data", set_data, 32'h3);
        check("wr_busy", 32'(busy), 32'd1);
        check("wr_noack", 32'(ack), 32'd0);
        @(negedge clk);
        check("wr_stb_off", 32'(set_stb), 32'd0);
        check("wr_ack", 32'(ack), 32'b0010);
        check("wr_rdata_kept", rdata, 32'd0);
        req = 4'b0000;
        @(negedge clk);
        check("wr_ack_off", 32'(ack), 32'd0);
        check("wr_idle", 32'(busy), 32'd0);

        // Single read from requester 2
        set_req(2, 1'b0, 32'h0, 32'h0);
        req = 4'b0100;
        @(negedge clk);
        check("rd_get_addr", get_addr, 32'h0);
        check("rd_busy", 32'(busy), 32'd1);
        check("rd_no_stb", 32'(set_stb), 32'd0);
        @(negedge clk);
        check("rd_ack", 32'(ack), 32'b0100);
        check("rd_rdata", rdata, 32'hACE0BA53);
        req = 4'b0000;
        @(negedge clk);
        check("rd_ack_off", 32'(ack), 32'd0);
        check("rd_rdata_hold", rdata, 32'hACE0BA53);
        check("rd_set_addr_hold", set_addr, 32'h8);

        // Read at a non-zero address from requester 3
        set_req(3, 1'b0, 32'h20, 32'h0);
        req = 4'b1000;
        @(negedge clk);
        check("rd2_get_addr", get_addr, 32'h20);
        @(negedge clk);
        check("rd2_ack", 32'(ack), 32'b1000);
        check("rd2_rdata", rdata, 32'h5A5A0020);
        req = 4'b0000;
        @(negedge clk);

        // All four requesting continuously after reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 32'h100 + 32'(i), 32'hD0 + 32'(i));
        req = 4'b1111;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k % 3 == 1) begin
                check("rr4_stb", 32'(set_stb), 32'd1);
                check("rr4_addr", set_addr, 32'h100 + 32'(order4[(k-1)/3]));
                check("rr4_data", set_data, 32'hD0 + 32'(order4[(k-1)/3]));
            end else if (k % 3 == 2) begin
                check("rr4_ack", 32'(ack), onehot(order4[(k-2)/3]));
            end else begin
                check("rr4_idle_ack", 32'(ack), 32'd0);
                check("rr4_idle_busy", 32'(busy), 32'd0);
            end
            if (k == 14) req = 4'b0000;
        end

        // Requesters 0 and 3 contend
        req = 4'b1001;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k % 3 == 1) begin
                check("rr2_addr", set_addr, 32'h100 + 32'(order2[(k-1)/3]));
            end else if (k % 3 == 2) begin
                check("rr2_ack", 32'(ack), onehot(order2[(k-2)/3]));
            end else begin
                check("rr2_idle_ack", 32'(ack), 32'd0);
            end
            if (k == 8) req = 4'b0000;
        end

        // Reset during the WRITE cycle, then re-grant of the pending request
        set_req(1, 1'b1, 32'h44, 32'h55);
        req = 4'b0010;
        @(negedge clk);
        check("ab_stb", 32'(set_stb), 32'd1);
        rst = 1'b1;
        #1;
        check("ab_stb_drop", 32'(set_stb), 32'd0);
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_ack", 32'(ack), 32'd0);
        @(negedge clk);
        check("ab_ack_hold", 32'(ack), 32'd0);
        check("ab_set_addr_rst", set_addr, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ab_regrant_stb", 32'(set_stb), 32'd1);
        check("ab_regrant_addr", set_addr, 32'h44);
        check("ab_regrant_data", set_data, 32'h55);
        @(negedge clk);
        check("ab_regrant_ack", 32'(ack), 32'b0010);
        req = 4'b0000;
        @(negedge clk);
        check("ab_end_ack", 32'(ack), 32'd0);
        check("ab_end_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
